// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC front end.
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        ACCUM = 2'd2
    } state_t;

    localparam int CNT_W_DEF  = 16;
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for an asynchronous comparator level, followed by a
// one-cycle pulse on each synchronised rising edge.
module edge_sync
    import tdc_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic pulse_o
);

    logic [DEPTH-1:0] sync_q;
    logic             prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], async_i};
            prev_q <= sync_q[DEPTH-1];
        end
    end

    assign pulse_o = sync_q[DEPTH-1] & ~prev_q;

endmodule

// File: rtl/tdc_diff_meas.sv
// Measures START->STOP intervals in clk cycles, averages 2^AVG_LOG2 of them,
// removes a calibration offset and publishes the result on frame_tick.
module tdc_diff_meas
    import tdc_pkg::*;
#(
    parameter int               CNT_W      = CNT_W_DEF,
    parameter int               AVG_LOG2   = 2,
    parameter logic [CNT_W-1:0] MAX_CNT    = CNT_W'(16'hFFF0),
    parameter logic [CNT_W-1:0] CAL_OFFSET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic             stop_in,
    input  logic             frame_tick,
    output logic [CNT_W-1:0] diffout,
    output logic             diff_valid,
    output logic [7:0]       err_cnt
);

    localparam int               ACC_W  = CNT_W + AVG_LOG2;
    localparam int               N_W    = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [N_W-1:0]   N_LAST = N_W'((1 << AVG_LOG2) - 1);

    logic stE, spE;

    edge_sync #(.DEPTH(SYNC_DEPTH)) u_start_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (start_in),
        .pulse_o (stE)
    );

    edge_sync #(.DEPTH(SYNC_DEPTH)) u_stop_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (stop_in),
        .pulse_o (spE)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] sample_q, sample_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pendV_q, pendV_d;
    logic [CNT_W-1:0] diffout_q, diffout_d;
    logic             valid_q, valid_d;
    logic [7:0]       err_q, err_d;

    logic [CNT_W:0]   cntInc;
    logic [ACC_W-1:0] accSum;
    logic [CNT_W-1:0] avgRaw, avgCal;
    logic             errInc;

    // cntInc is the interval a stop edge in this cycle would report
    assign cntInc = {1'b0, cnt_q} + 1'b1;
    assign accSum = acc_q + ACC_W'(sample_q);
    assign avgRaw = CNT_W'(accSum >> AVG_LOG2);
    assign avgCal = (avgRaw > CAL_OFFSET) ? (avgRaw - CAL_OFFSET) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sample_q  <= '0;
            acc_q     <= '0;
            n_q       <= '0;
            pend_q    <= '0;
            pendV_q   <= 1'b0;
            diffout_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            acc_q     <= acc_d;
            n_q       <= n_d;
            pend_q    <= pend_d;
            pendV_q   <= pendV_d;
            diffout_q <= diffout_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    // Publish uses the old pending value, so a result landing on a tick waits.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sample_d  = sample_q;
        acc_d     = acc_q;
        n_d       = n_q;
        pend_d    = pend_q;
        pendV_d   = pendV_q;
        diffout_d = diffout_q;
        valid_d   = valid_q;
        errInc    = 1'b0;

        if (frame_tick && pendV_q) begin
            diffout_d = pend_q;
            valid_d   = 1'b1;
            pendV_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (stE) begin
                    cnt_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                cnt_d = cnt_q + 1'b1;
                // Timeout beats a coincident stop so every sample stays below MAX_CNT
                if (cntInc >= {1'b0, MAX_CNT}) begin
                    errInc  = 1'b1;
                    state_d = IDLE;
                end else if (spE) begin
                    sample_d = cntInc[CNT_W-1:0];
                    state_d  = ACCUM;
                end else if (stE) begin
                    cnt_d  = '0;
                    errInc = 1'b1;
                end
            end
            ACCUM: begin
                acc_d = accSum;
                n_d   = n_q + 1'b1;
                if (n_q == N_LAST) begin
                    pend_d  = avgCal;
                    pendV_d = 1'b1;
                    acc_d   = '0;
                    n_d     = '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        err_d = (errInc && (err_q != 8'hFF)) ? (err_q + 8'd1) : err_q;
    end

    assign diffout    = diffout_q;
    assign diff_valid = valid_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_tdc_diff_meas.sv
// Bench for tdc_diff_meas: three parameterisations share one stimulus stream and
// are checked every cycle against a timestamp-based interval model.
`timescale 1ns/1ps
module tb_tdc_diff_meas;

    localparam int NDUT = 3;
    localparam int AVG_L [NDUT] = '{0, 2, 0};
    localparam int MAXC  [NDUT] = '{128, 65520, 65520};
    localparam int CAL   [NDUT] = '{0, 0, 10};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        startIn, stopIn, frameTick;
    logic [15:0] dout  [NDUT];
    logic        valid [NDUT];
    logic [7:0]  err   [NDUT];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tdc_diff_meas #(.CNT_W(16), .AVG_LOG2(0), .MAX_CNT(16'h0080), .CAL_OFFSET(16'd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_in(startIn), .stop_in(stopIn), .frame_tick(frameTick),
        .diffout(dout[0]), .diff_valid(valid[0]), .err_cnt(err[0]));

    tdc_diff_meas #(.CNT_W(16), .AVG_LOG2(2), .MAX_CNT(16'hFFF0), .CAL_OFFSET(16'd0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_in(startIn), .stop_in(stopIn), .frame_tick(frameTick),
        .diffout(dout[1]), .diff_valid(valid[1]), .err_cnt(err[1]));

    tdc_diff_meas #(.CNT_W(16), .AVG_LOG2(0), .MAX_CNT(16'hFFF0), .CAL_OFFSET(16'd10)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_in(startIn), .stop_in(stopIn), .frame_tick(frameTick),
        .diffout(dout[2]), .diff_valid(valid[2]), .err_cnt(err[2]));

    // Model: an edge on an input level is seen two clocks after it is sampled;
    // intervals are differences of edge timestamps.
    logic [2:0] hS, hP;
    int         cyc;
    bit         mActive [NDUT];
    bit         mSkip   [NDUT];
    int         mT0     [NDUT];
    int         mSample [NDUT];
    longint     mAcc    [NDUT];
    int         mN      [NDUT];
    int         mPend   [NDUT];
    bit         mPendV  [NDUT];
    int         mDout   [NDUT];
    bit         mValid  [NDUT];
    int         mErr    [NDUT];

    bit     st, sp, pvNew, bump;
    int     k;
    longint sum, avg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hS  <= '0;
            hP  <= '0;
            cyc <= 0;
            for (int i = 0; i < NDUT; i++) begin
                mActive[i] <= 1'b0; mSkip[i] <= 1'b0; mT0[i] <= 0; mSample[i] <= 0;
                mAcc[i] <= 0; mN[i] <= 0; mPend[i] <= 0; mPendV[i] <= 1'b0;
                mDout[i] <= 0; mValid[i] <= 1'b0; mErr[i] <= 0;
            end
        end else begin
            st = hS[1] & ~hS[2];
            sp = hP[1] & ~hP[2];
            hS  <= {hS[1:0], startIn};
            hP  <= {hP[1:0], stopIn};
            cyc <= cyc + 1;
            for (int i = 0; i < NDUT; i++) begin
                pvNew = mPendV[i];
                bump  = 1'b0;
                if (frameTick && mPendV[i]) begin
                    mDout[i]  <= mPend[i];
                    mValid[i] <= 1'b1;
                    pvNew = 1'b0;
                end
                if (mSkip[i]) begin
                    mSkip[i] <= 1'b0;
                    sum = mAcc[i] + mSample[i];
                    if (mN[i] + 1 == (1 << AVG_L[i])) begin
                        avg = sum >> AVG_L[i];
                        mPend[i] <= (avg > CAL[i]) ? int'(avg - CAL[i]) : 0;
                        pvNew = 1'b1;
                        mAcc[i] <= 0;
                        mN[i]   <= 0;
                    end else begin
                        mAcc[i] <= sum;
                        mN[i]   <= mN[i] + 1;
                    end
                end else if (mActive[i]) begin
                    k = cyc - mT0[i];
                    if (k >= MAXC[i]) begin
                        bump = 1'b1;
                        mActive[i] <= 1'b0;
                    end else if (sp) begin
                        mSample[i] <= k;
                        mSkip[i]   <= 1'b1;
                        mActive[i] <= 1'b0;
                    end else if (st) begin
                        bump = 1'b1;
                        mT0[i] <= cyc;
                    end
                end else if (st) begin
                    mActive[i] <= 1'b1;
                    mT0[i]     <= cyc;
                end
                if (bump && mErr[i] < 255) mErr[i] <= mErr[i] + 1;
                mPendV[i] <= pvNew;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            total += 3;
            if (int'(dout[i]) != mDout[i]) begin
                bad++;
                $display("[TB] FAIL diffout[%0d] cyc=%0d got=%0d want=%0d", i, cyc, dout[i], mDout[i]);
            end
            if (valid[i] != mValid[i]) begin
                bad++;
                $display("[TB] FAIL diff_valid[%0d] cyc=%0d got=%0d want=%0d", i, cyc, valid[i], mValid[i]);
            end
            if (int'(err[i]) != mErr[i]) begin
                bad++;
                $display("[TB] FAIL err_cnt[%0d] cyc=%0d got=%0d want=%0d", i, cyc, err[i], mErr[i]);
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Start rise, stop rise `gap` clocks later, then idle long enough for ACCUM.
    task automatic applyStimulus(input int gap);
        startIn = 1'b1;
        repeat (gap) @(negedge clk);
        stopIn = 1'b1;
        repeat (2) @(negedge clk);
        startIn = 1'b0;
        stopIn  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulseTick();
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; startIn = 1'b0; stopIn = 1'b0; frameTick = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset diffout", int'(dout[0]), 0);
        checkOutput("reset valid",   int'(valid[0]), 0);
        checkOutput("reset err",     int'(err[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(100);
        pulseTick();
        checkOutput("single 100", int'(dout[0]), 100);
        checkOutput("single valid", int'(valid[0]), 1);
        checkOutput("cal 100-10", int'(dout[2]), 90);

        applyStimulus(102);
        applyStimulus(104);
        applyStimulus(106);
        pulseTick();
        checkOutput("avg4 103", int'(dout[1]), 103);
        pulseTick();
        checkOutput("avg4 hold", int'(dout[1]), 103);

        applyStimulus(140);
        checkOutput("timeout err", int'(err[0]), 1);
        pulseTick();
        checkOutput("timeout hold", int'(dout[0]), 106);

        startIn = 1'b1;
        repeat (5) @(negedge clk);
        startIn = 1'b0;
        repeat (15) @(negedge clk);
        applyStimulus(50);
        pulseTick();
        checkOutput("retrig sample", int'(dout[0]), 50);
        checkOutput("retrig err", int'(err[0]), 2);

        applyStimulus(6);
        pulseTick();
        checkOutput("cal clamp", int'(dout[2]), 0);

        // Tick lands on the ACCUM cycle: result must wait for the next tick.
        startIn = 1'b1;
        repeat (30) @(negedge clk);
        stopIn = 1'b1;
        repeat (3) @(negedge clk);
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0; startIn = 1'b0; stopIn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("same-cycle hold", int'(dout[0]), 6);
        pulseTick();
        checkOutput("same-cycle next", int'(dout[0]), 30);

        applyStimulus(20);
        startIn = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset diffout", int'(dout[0]), 0);
        checkOutput("midreset valid", int'(valid[0]), 0);
        checkOutput("midreset err", int'(err[1]), 0);
        startIn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulseTick();
        checkOutput("no stale pending", int'(valid[0]), 0);
        applyStimulus(40);
        pulseTick();
        checkOutput("post-reset 40", int'(dout[0]), 40);
        checkOutput("post-reset cal", int'(dout[2]), 30);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) startIn = ~startIn;
            if ($urandom_range(0, 39) == 0) stopIn = ~stopIn;
            frameTick = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        startIn = 1'b0; stopIn = 1'b0; frameTick = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
